// File: rtl/cdc_frame_pkg.sv
// Frame format constants and helpers shared by the upload packer and the download parser.
// Wire format: AA 55 CMD LEN_H LEN_L PAYLOAD[0..LEN-1] CHECKSUM.
package cdc_frame_pkg;

  localparam logic [7:0] FRAME_SYNC0 = 8'hAA;
  localparam logic [7:0] FRAME_SYNC1 = 8'h55;

  typedef enum logic [2:0] {
    StIdle,
    StSync0,
    StSync1,
    StCmd,
    StLenH,
    StLenL,
    StPayload,
    StCsum
  } frame_tx_state_t;

  // 8-bit wrapping sum; sync bytes are never fed in.
  function automatic logic [7:0] frame_csum_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

endpackage

// File: rtl/upload_frame_packer_if.sv
// Byte stream with valid/ready handshake; used for the payload input and the USB upload output.
interface upload_frame_packer_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/upload_frame_packer.sv
// Transmit framer: wraps cmd, 16-bit len and a streamed payload into AA 55 CMD LENH LENL PAY.. CSUM.
// The state names the byte currently sitting in the output register; PAYLOAD consumes producer bytes.
module upload_frame_packer
  import cdc_frame_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            cmd,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  upload_frame_packer_if.slave  payload,
  upload_frame_packer_if.master usb
);

  frame_tx_state_t  state_q, state_d;
  logic             csum_sent_q, csum_sent_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic [15:0] len_wire;
  logic        load_ok;
  logic        pay_ready;
  logic        xfer;

  assign len_wire  = 16'(len_q);
  assign load_ok   = !valid_q || usb.ready;
  assign pay_ready = (state_q == StPayload) && load_ok;
  assign xfer      = payload.valid && pay_ready;

  always_comb begin
    state_d     = state_q;
    csum_sent_d = csum_sent_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    data_d      = data_q;
    valid_d     = valid_q && !usb.ready;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        // Output register is always empty here, so AA goes out right away.
        if (start) begin
          cmd_d       = cmd;
          len_d       = len;
          cnt_d       = '0;
          csum_d      = '0;
          csum_sent_d = 1'b0;
          data_d      = FRAME_SYNC0;
          valid_d     = 1'b1;
          state_d     = StSync0;
        end
      end
      StSync0: begin
        if (load_ok) begin
          data_d  = FRAME_SYNC1;
          valid_d = 1'b1;
          state_d = StSync1;
        end
      end
      StSync1: begin
        if (load_ok) begin
          data_d  = cmd_q;
          valid_d = 1'b1;
          csum_d  = frame_csum_add(csum_q, cmd_q);
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (load_ok) begin
          data_d  = len_wire[15:8];
          valid_d = 1'b1;
          csum_d  = frame_csum_add(csum_q, len_wire[15:8]);
          state_d = StLenH;
        end
      end
      StLenH: begin
        // With payload pending, PAYLOAD starts consuming while LEN_L is still on the wire.
        if (load_ok) begin
          data_d  = len_wire[7:0];
          valid_d = 1'b1;
          csum_d  = frame_csum_add(csum_q, len_wire[7:0]);
          state_d = (len_q == '0) ? StLenL : StPayload;
        end
      end
      StLenL: begin
        if (load_ok) begin
          data_d      = csum_q;
          valid_d     = 1'b1;
          csum_sent_d = 1'b1;
          state_d     = StCsum;
        end
      end
      StPayload: begin
        if (xfer) begin
          data_d  = payload.data;
          valid_d = 1'b1;
          csum_d  = frame_csum_add(csum_q, payload.data);
          cnt_d   = cnt_q + LEN_W'(1);
          if ((cnt_q + LEN_W'(1)) == len_q) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (!csum_sent_q) begin
          if (load_ok) begin
            data_d      = csum_q;
            valid_d     = 1'b1;
            csum_sent_d = 1'b1;
          end
        end else if (valid_q && usb.ready) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      csum_sent_q <= 1'b0;
      cmd_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      csum_sent_q <= csum_sent_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign payload.ready = pay_ready;
  assign usb.data      = data_q;
  assign usb.valid     = valid_q;

endmodule

// File: tb/tb_upload_frame_packer.sv
// Directed bench for upload_frame_packer: table of frames plus hand-written sequences for
// restart-while-busy, reset mid-payload, a 256-byte frame and back-to-back frames.
module tb_upload_frame_packer;
  import cdc_frame_pkg::*;

  typedef struct {
    logic [7:0]      cmd;
    logic [15:0]     len;
    logic [0:3][7:0] pl;
    logic [0:9][7:0] want;
    int              n;
    bit              rnd;
  } vec_t;

  logic        clk, rst_n, start, busy, done;
  logic [7:0]  cmd;
  logic [15:0] len;
  logic [7:0]  payload_data, usb_data;
  logic        payload_valid, payload_ready, usb_valid, usb_ready;

  upload_frame_packer_if pl_if ();
  upload_frame_packer_if usb_if ();

  assign pl_if.data   = payload_data;
  assign pl_if.valid  = payload_valid;
  assign payload_ready = pl_if.ready;
  assign usb_data     = usb_if.data;
  assign usb_valid    = usb_if.valid;
  assign usb_if.ready = usb_ready;

  upload_frame_packer #(.LEN_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmd    (cmd),
    .len    (len),
    .busy   (busy),
    .done   (done),
    .payload(pl_if),
    .usb    (usb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         nvec, nfail, cyc, first_v, done_cyc, hold_viol;
  bit         pr_seen, hold_pend, xfer_seen;
  logic [7:0] hold_data;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] pbytes [0:511];
  vec_t       vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic clr_mon();
    got.delete();
    first_v   = -1;
    pr_seen   = 1'b0;
    hold_viol = 0;
  endtask

  // One clock: observe at the falling edge, return just after the next rising edge.
  task automatic step();
    @(negedge clk);
    xfer_seen = payload_valid && payload_ready;
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && !(usb_valid && usb_data == hold_data)) hold_viol++;
      hold_pend = usb_valid && !usb_ready;
      hold_data = usb_data;
      if (usb_valid && usb_ready) got.push_back(usb_data);
      if (usb_valid && first_v < 0) first_v = cyc;
      if (payload_ready) pr_seen = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic load_exp(input logic [0:9][7:0] w, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
  endtask

  task automatic check_stream(input string name);
    logic [7:0] a;
    check({name, " length"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      a = (i < got.size()) ? got[i] : 8'h00;
      check($sformatf("%s byte%0d", name, i), 32'(a), 32'(exp_q[i]));
    end
  endtask

  // Returns in the cycle where done is high, so a caller may chain the next start immediately.
  task automatic send_frame(input logic [7:0] c, input logic [15:0] l, input bit rnd,
                            input int restart_at);
    int pidx;
    bit fin;
    pidx = 0;
    fin  = 1'b0;
    clr_mon();
    start         = 1'b1;
    cmd           = c;
    len           = l;
    payload_data  = pbytes[0];
    payload_valid = (l != 16'd0);
    usb_ready     = 1'b1;
    step();
    if (xfer_seen) pidx++;
    check("first busy", 32'(busy), 32'd1);
    check("first valid", 32'(usb_valid), 32'd1);
    check("first byte", 32'(usb_data), 32'(FRAME_SYNC0));
    cmd = c ^ 8'h5A;
    len = l + 16'd7;
    for (int k = 0; k < 3000 && !fin; k++) begin
      start         = (k == restart_at);
      payload_data  = pbytes[pidx[8:0]];
      payload_valid = (pidx < int'(l)) && (!rnd || ($urandom_range(0, 2) != 0));
      usb_ready     = !rnd || ($urandom_range(0, 1) == 1);
      step();
      if (xfer_seen) pidx++;
      if (done) begin
        fin      = 1'b1;
        done_cyc = cyc;
      end
    end
    start         = 1'b0;
    payload_valid = 1'b0;
    usb_ready     = 1'b1;
    check("done seen", 32'(fin), 32'd1);
    check("busy low at done", 32'(busy), 32'd0);
    check("held byte stable", 32'(hold_viol), 32'd0);
    check("payload consumed", 32'(pidx), 32'(l));
    if (!rnd) check("done latency", 32'(done_cyc - first_v), 32'(6 + int'(l)));
    if (l == 16'd0) check("payload_ready idle", 32'(pr_seen), 32'd0);
  endtask

  task automatic add_vec(input logic [7:0] c, input logic [15:0] l, input logic [0:3][7:0] p,
                         input logic [0:9][7:0] w, input int n, input bit r);
    vec_t v;
    v.cmd  = c;
    v.len  = l;
    v.pl   = p;
    v.want = w;
    v.n    = n;
    v.rnd  = r;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;
    int   d1, pi;
    nvec = 0; nfail = 0; cyc = 0; done_cyc = 0; hold_pend = 1'b0; hold_data = 8'h00;
    clr_mon();
    start = 1'b0; cmd = 8'h00; len = 16'd0;
    payload_data = 8'h00; payload_valid = 1'b1; usb_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    check("reset valid", 32'(usb_valid), 32'd0);
    check("reset data", 32'(usb_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset payload_ready", 32'(payload_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    add_vec(8'hFD, 16'd0, {8'h00, 8'h00, 8'h00, 8'h00},
            {8'hAA, 8'h55, 8'hFD, 8'h00, 8'h00, 8'hFD, 8'h00, 8'h00, 8'h00, 8'h00}, 6, 1'b0);
    add_vec(8'h0B, 16'd3, {8'h01, 8'h02, 8'h03, 8'h00},
            {8'hAA, 8'h55, 8'h0B, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h14, 8'h00}, 9, 1'b0);
    add_vec(8'h0B, 16'd3, {8'h01, 8'h02, 8'h03, 8'h00},
            {8'hAA, 8'h55, 8'h0B, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h14, 8'h00}, 9, 1'b1);
    add_vec(8'hFF, 16'd2, {8'hFF, 8'hFF, 8'h00, 8'h00},
            {8'hAA, 8'h55, 8'hFF, 8'h00, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00}, 8, 1'b0);
    add_vec(8'h3C, 16'd4, {8'h10, 8'h20, 8'h30, 8'h40},
            {8'hAA, 8'h55, 8'h3C, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hE0}, 10, 1'b1);
    add_vec(8'hFD, 16'd0, {8'h00, 8'h00, 8'h00, 8'h00},
            {8'hAA, 8'h55, 8'hFD, 8'h00, 8'h00, 8'hFD, 8'h00, 8'h00, 8'h00, 8'h00}, 6, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      for (int j = 0; j < 4; j++) pbytes[j] = v.pl[j];
      send_frame(v.cmd, v.len, v.rnd, -1);
      load_exp(v.want, v.n);
      check_stream($sformatf("vec%0d", i));
      step();
      step();
    end

    // start pulsed mid-payload with different cmd/len must not disturb the stream
    pbytes[0] = 8'h01; pbytes[1] = 8'h02; pbytes[2] = 8'h03;
    send_frame(8'h0B, 16'd3, 1'b0, 5);
    load_exp({8'hAA, 8'h55, 8'h0B, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h14, 8'h00}, 9);
    check_stream("restart");
    step();

    // 256-byte frame: LEN bytes 01 00, checksum 0A+01+00+sum(0..255) = 8B
    for (int i = 0; i < 256; i++) pbytes[i] = 8'(i);
    send_frame(8'h0A, 16'd256, 1'b0, -1);
    exp_q.delete();
    exp_q.push_back(8'hAA); exp_q.push_back(8'h55); exp_q.push_back(8'h0A);
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h8B);
    check_stream("len256");
    step();

    // Reset in the middle of the payload phase
    pbytes[0] = 8'h11; pbytes[1] = 8'h22; pbytes[2] = 8'h33; pbytes[3] = 8'h44;
    clr_mon();
    start = 1'b1; cmd = 8'h21; len = 16'd4;
    payload_data = pbytes[0]; payload_valid = 1'b1; usb_ready = 1'b1;
    pi = 0;
    step();
    start = 1'b0;
    repeat (5) begin
      payload_data = pbytes[pi];
      step();
      if (xfer_seen) pi++;
    end
    payload_data = pbytes[pi];
    check("mid-payload ready", 32'(payload_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset valid", 32'(usb_valid), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset payload_ready", 32'(payload_ready), 32'd0);
    check("async reset data", 32'(usb_data), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    clr_mon();
    repeat (3) step();
    check("no resume after reset", 32'(first_v >= 0), 32'd0);
    pbytes[0] = 8'h99;
    send_frame(8'h05, 16'd1, 1'b0, -1);
    load_exp({8'hAA, 8'h55, 8'h05, 8'h00, 8'h01, 8'h99, 8'h9F, 8'h00, 8'h00, 8'h00}, 7);
    check_stream("post-reset");
    step();

    // Back-to-back: second start lands in the done cycle of the first
    pbytes[0] = 8'h01; pbytes[1] = 8'h02; pbytes[2] = 8'h03;
    send_frame(8'h0B, 16'd3, 1'b0, -1);
    d1 = done_cyc;
    load_exp({8'hAA, 8'h55, 8'h0B, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h14, 8'h00}, 9);
    check_stream("b2b first");
    pbytes[0] = 8'hFF; pbytes[1] = 8'hFF;
    send_frame(8'hFF, 16'd2, 1'b0, -1);
    check("b2b gap", 32'(first_v - d1), 32'd1);
    load_exp({8'hAA, 8'h55, 8'hFF, 8'h00, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00}, 8);
    check_stream("b2b second");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/upload_frame_packer.md
# upload_frame_packer

Transmit-side framer for the USB upload path: wraps a command code, a 16-bit length and a streamed payload into the same frame format the command parser accepts on the download side. Wire format: `AA 55 CMD LEN_H LEN_L PAYLOAD[0..LEN-1] CHECKSUM`. It sits between upload producers (logic analyser, DC capture, status responders) and the `usb_upload_data`/`usb_upload_valid` outputs of `cdc`. Output is fully registered and honours downstream backpressure.

## Interface
Parameters:
- `LEN_W`, 16: width of the length field. The wire field is always 2 bytes; values above 65535 are illegal.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock (60 MHz domain)
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  single-cycle frame request; sampled only in IDLE
- `cmd`  in  8  command code; latched on accepted `start`
- `len`  in  LEN_W  payload byte count; latched on accepted `start`; 0 is legal
- `busy`  out  1  high from accepted `start` through the checksum handshake
- `done`  out  1  one-cycle pulse after the checksum byte is accepted
- `payload_data`  in  8  payload byte from the producer
- `payload_valid`  in  1  producer has a byte
- `payload_ready`  out  1  packer consumes `payload_data` this cycle
- `usb_upload_data`  out  8  framed byte
- `usb_upload_valid`  out  1  `usb_upload_data` is valid
- `usb_upload_ready`  in  1  sink accepts the byte; tie high if the sink never stalls

## Operation
- States: IDLE → SYNC0 → SYNC1 → CMD → LENH → LENL → PAYLOAD → CSUM → IDLE. LENL goes directly to CSUM when the latched `len` is 0.
- Output register (`usb_upload_data`/`usb_upload_valid`) loads when it is empty or is being consumed (`!valid || ready`). A state advances only when its byte loads.
- Accepted `start` in IDLE latches `cmd` and `len`, clears the byte counter, and seeds the checksum with 0.
- Checksum is an 8-bit wrapping sum of CMD, LEN_H, LEN_L and every payload byte. It excludes AA and 55.
- PAYLOAD: `payload_ready = (state==PAYLOAD) && (!usb_upload_valid || usb_upload_ready)`. A byte transfers when `payload_valid && payload_ready`. The counter increments per transfer; the packer leaves PAYLOAD after transfer number `len`.
- Producer underrun (no `payload_valid`): no byte loads, `usb_upload_valid` drops once the held byte is consumed, and the frame resumes when data returns. There is no timeout.
- `start` while `busy` is ignored. `cmd` and `len` changes mid-frame have no effect.
- `done` pulses in the cycle after the CSUM byte handshake (`valid && ready`). `busy` falls in that same cycle.

## Timing
- Reset values: `usb_upload_data`=0, `usb_upload_valid`=0, `payload_ready`=0, `busy`=0, `done`=0, state IDLE, checksum 0.
- `start` at cycle t → `usb_upload_valid`=1 with AA at t+1, and `busy`=1 at t+1.
- With ready held high and payload always valid, one byte is emitted per cycle, so a frame occupies 6+LEN consecutive valid cycles. `done` is asserted 1 cycle after CSUM is presented.
- Byte hold: while `valid && !ready`, data and valid are held stable.
- Payload latency: a byte transferred at cycle t appears on `usb_upload_data` at t+1.
- Reset mid-frame: all outputs return to their reset values asynchronously. No partial frame resumes after reset release.
- Back-to-back frames: `start` in the same cycle `done` is high is accepted, because the state is already IDLE. The gap between frames is 1 cycle.

## Structure
- Shared package `cdc_frame_pkg` holds:
  - `FRAME_SYNC0=8'hAA` and `FRAME_SYNC1=8'h55`
  - the frame state enum `frame_tx_state_t`
  - a `frame_csum_add(acc, byte)` function, also used by the parser side
- No sub-module. This is a single FSM with an output register, roughly 150–250 lines.

## Test plan
1. Empty frame: `start`, cmd=0xFD, len=0, ready high → stream AA 55 FD 00 00 FD; `done` 6 cycles after the first valid; `payload_ready` never asserted.
2. Short frame: cmd=0x0B, len=3, payload 01 02 03 → stream AA 55 0B 00 03 01 02 03 14.
3. Backpressure and underrun: repeat scenario 2 with random `usb_upload_ready` and random `payload_valid` gaps → identical byte sequence; data stable while `valid && !ready`; no byte duplicated or dropped.
4. Checksum wrap: cmd=0xFF, len=2, payload FF FF → checksum 0xFF. Also cmd=0x0A, len=256, payload 00..FF → LEN bytes 01 00, checksum 0x8B.
5. Ignored restart and mid-frame reset: `start` pulsed during PAYLOAD → no effect on the stream. `rst_n` low mid-payload → `usb_upload_valid`, `busy`, `payload_ready` = 0 immediately; next `start` emits a fresh AA.
6. Back-to-back: `start` asserted in the `done` cycle → second frame's AA appears 1 cycle later with no corruption of either checksum.
